// File: rtl/nx_ram_1rw_ctl_pkg.sv
// Shared types for the single-port RAM controller: FSM states, grant encoding, address width.
package nx_ram_1rw_ctl_pkg;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } gnt_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nx_rr_arb2.sv
// Two-requester round-robin arbiter; prio_b forces requester b to win every contended cycle.
// Grants are combinational; the favour pointer only moves on contended round-robin grants.
module nx_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic prio_b,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic fav_b;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        if (prio_b || fav_b) gnt_b = 1'b1;
        else                 gnt_a = 1'b1;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // After a contended grant, favour whoever lost it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fav_b <= 1'b0;
    end else if (en && req_a && req_b && !prio_b) begin
      fav_b <= gnt_a;
    end
  end

endmodule

// File: rtl/nx_ram_1rw_ctl.sv
// Shares one 1RW RAM between a write and a read requester, with a post-reset/on-demand init sweep.
// Acks are combinational with the RAM access; rd_dvld follows rd_ack by one cycle.
module nx_ram_1rw_ctl
  import nx_ram_1rw_ctl_pkg::*;
#(
  parameter int              WIDTH    = 64,
  parameter int              DEPTH    = 256,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter int              RD_PRIO  = 0,
  localparam int             AW       = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_start,
  output logic             init_done,
  input  logic             wr_req,
  input  logic [AW-1:0]    wr_add,
  input  logic [WIDTH-1:0] wr_din,
  input  logic [WIDTH-1:0] wr_bwe,
  output logic             wr_ack,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_add,
  output logic             rd_ack,
  output logic             rd_dvld,
  output logic [WIDTH-1:0] rd_dout,
  output logic             ram_cs,
  output logic             ram_we,
  output logic [AW-1:0]    ram_add,
  output logic [WIDTH-1:0] ram_din,
  output logic [WIDTH-1:0] ram_bwe,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          gnt_wr, gnt_rd;
  gnt_t          gnt;

  nx_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (rst_n && (state == ST_IDLE)),
    .prio_b (RD_PRIO != 0),
    .req_a  (wr_req),
    .req_b  (rd_req),
    .gnt_a  (gnt_wr),
    .gnt_b  (gnt_rd)
  );

  assign gnt       = gnt_wr ? GNT_WR : (gnt_rd ? GNT_RD : GNT_NONE);
  assign wr_ack    = (gnt == GNT_WR);
  assign rd_ack    = (gnt == GNT_RD);
  assign init_done = (state == ST_IDLE);
  assign rd_dout   = ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      cnt     <= '0;
      rd_dvld <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rd_dvld <= rd_ack;
    end
  end

  // init_start overrides everything, including a sweep already in progress.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (init_start) begin
      state_nxt = ST_INIT;
      cnt_nxt   = '0;
    end else if (state == ST_INIT) begin
      if (cnt == LAST) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + AW'(1);
      end
    end
  end

  always_comb begin
    ram_cs  = 1'b0;
    ram_we  = 1'b0;
    ram_add = '0;
    ram_din = '0;
    ram_bwe = '0;
    if (rst_n && (state == ST_INIT)) begin
      ram_cs  = 1'b1;
      ram_we  = 1'b1;
      ram_add = cnt;
      ram_din = INIT_VAL;
      ram_bwe = '1;
    end else begin
      case (gnt)
        GNT_WR: begin
          ram_cs  = 1'b1;
          ram_we  = 1'b1;
          ram_add = wr_add;
          ram_din = wr_din;
          ram_bwe = wr_bwe;
        end
        GNT_RD: begin
          ram_cs  = 1'b1;
          ram_add = rd_add;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nx_ram_1rw_ctl.sv
// Bench: two controllers (round-robin and read-priority) on shared stimulus, each with its own RAM.
module tb_nx_ram_1rw_ctl;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam logic [W-1:0] IV = 16'h00A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          init_start = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_add = '0, rd_add = '0;
  logic [W-1:0]  wr_din = '0, wr_bwe = '0;

  logic          init_done [2], wr_ack [2], rd_ack [2], rd_dvld [2], ram_cs [2], ram_we [2];
  logic [W-1:0]  rd_dout [2], ram_din [2], ram_bwe [2], ram_dout [2];
  logic [AW-1:0] ram_add [2];
  logic [W-1:0]  ram_mem [2][D];

  int n_cmp = 0, n_bad = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nx_ram_1rw_ctl #(.WIDTH(W), .DEPTH(D), .INIT_VAL(IV), .RD_PRIO(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(init_done[g]),
      .wr_req(wr_req), .wr_add(wr_add), .wr_din(wr_din), .wr_bwe(wr_bwe), .wr_ack(wr_ack[g]),
      .rd_req(rd_req), .rd_add(rd_add), .rd_ack(rd_ack[g]), .rd_dvld(rd_dvld[g]),
      .rd_dout(rd_dout[g]), .ram_cs(ram_cs[g]), .ram_we(ram_we[g]), .ram_add(ram_add[g]),
      .ram_din(ram_din[g]), .ram_bwe(ram_bwe[g]), .ram_dout(ram_dout[g])
    );
  end

  // RAM with registered read and bit-enable write.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ram_cs[g]) begin
        if (ram_we[g])
          ram_mem[g][ram_add[g]] <= (ram_mem[g][ram_add[g]] & ~ram_bwe[g]) | (ram_din[g] & ram_bwe[g]);
        else
          ram_dout[g] <= ram_mem[g][ram_add[g]];
      end
    end
  end

  // Reference model: sweeping flag/position, who won the last contended cycle, pending read data, memory image.
  bit           m_init [2], m_wr_won_last [2], m_dv [2];
  int           m_cnt [2];
  logic [W-1:0] m_dv_dat [2];
  logic [W-1:0] m_mem [2][D];
  bit           e_wr [2], e_rd [2];
  logic         obs_wr [2], obs_rd [2], obs_cs [2], obs_dvld [2], obs_done [2];
  logic [AW-1:0] obs_add [2];
  logic [W-1:0] obs_dout [2];

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, g, $time, act, exp);
    end
  endtask

  task automatic check();
    for (int g = 0; g < 2; g++) begin
      bit ew, er, ecs, ewe;
      logic [AW-1:0] ea;
      logic [W-1:0] ed, eb;
      ew = 0; er = 0; ecs = 0; ewe = 0; ea = '0; ed = '0; eb = '0;
      if (rst_n) begin
        if (m_init[g]) begin
          ecs = 1; ewe = 1; ea = AW'(m_cnt[g]); ed = IV; eb = '1;
        end else begin
          if (wr_req && rd_req) begin
            if (g == 1 || m_wr_won_last[g]) er = 1;
            else ew = 1;
          end else begin
            ew = wr_req; er = rd_req;
          end
          if (ew) begin ecs = 1; ewe = 1; ea = wr_add; ed = wr_din; eb = wr_bwe; end
          if (er) begin ecs = 1; ea = rd_add; end
        end
      end
      e_wr[g] = ew; e_rd[g] = er;
      obs_wr[g] = wr_ack[g]; obs_rd[g] = rd_ack[g]; obs_cs[g] = ram_cs[g];
      obs_dvld[g] = rd_dvld[g]; obs_done[g] = init_done[g];
      obs_add[g] = ram_add[g]; obs_dout[g] = rd_dout[g];
      chk("init_done", g, 64'(init_done[g]), 64'(rst_n && !m_init[g]));
      chk("wr_ack", g, 64'(wr_ack[g]), 64'(ew));
      chk("rd_ack", g, 64'(rd_ack[g]), 64'(er));
      chk("ram_cs", g, 64'(ram_cs[g]), 64'(ecs));
      chk("rd_dvld", g, 64'(rd_dvld[g]), 64'(rst_n && m_dv[g]));
      if (ecs) begin
        chk("ram_we", g, 64'(ram_we[g]), 64'(ewe));
        chk("ram_add", g, 64'(ram_add[g]), 64'(ea));
        chk("ram_bwe", g, 64'(ram_bwe[g]), 64'(eb));
        if (ewe) chk("ram_din", g, 64'(ram_din[g]), 64'(ed));
      end
      if (rst_n && m_dv[g]) chk("rd_dout", g, 64'(rd_dout[g]), 64'(m_dv_dat[g]));
    end
  endtask

  task automatic update();
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        m_init[g] = 1; m_cnt[g] = 0; m_wr_won_last[g] = 0; m_dv[g] = 0;
      end else begin
        m_dv[g] = e_rd[g];
        if (e_rd[g]) m_dv_dat[g] = m_mem[g][rd_add];
        if (m_init[g]) m_mem[g][m_cnt[g]] = IV;
        if (e_wr[g]) m_mem[g][wr_add] = (m_mem[g][wr_add] & ~wr_bwe) | (wr_din & wr_bwe);
        if (g == 0 && wr_req && rd_req && !m_init[g]) m_wr_won_last[g] = e_wr[g];
        if (init_start) begin
          m_init[g] = 1; m_cnt[g] = 0;
        end else if (m_init[g]) begin
          if (m_cnt[g] == D - 1) begin m_init[g] = 0; m_cnt[g] = 0; end
          else m_cnt[g]++;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      m_init[g] = 1; m_cnt[g] = 0; m_wr_won_last[g] = 0; m_dv[g] = 0;
    end
    repeat (3) step();

    // Sweep with a read held pending the whole time.
    rst_n = 1'b1; rd_req = 1'b1; rd_add = 4'd5;
    for (int k = 0; k < D; k++) begin
      step();
      chk("sweep_cs", 0, 64'(obs_cs[0]), 64'd1);
      chk("sweep_add", 0, 64'(obs_add[0]), 64'(k));
      chk("sweep_rdack", 0, 64'(obs_rd[0]), 64'd0);
    end
    step();
    chk("done_c17", 0, 64'(obs_done[0]), 64'd1);
    chk("rdack_c17", 0, 64'(obs_rd[0]), 64'd1);
    rd_req = 1'b0;
    step();
    chk("rd_init_val", 0, 64'(obs_dout[0]), 64'h00A5);
    for (int g = 0; g < 2; g++)
      for (int w = 0; w < D; w++) chk("backdoor", g, 64'(ram_mem[g][w]), 64'h00A5);

    // Full write then read-back.
    wr_req = 1'b1; wr_add = 4'd3; wr_din = 16'h1234; wr_bwe = 16'hFFFF;
    step();
    chk("wr_ack_single", 0, 64'(obs_wr[0]), 64'd1);
    wr_req = 1'b0; rd_req = 1'b1; rd_add = 4'd3;
    step();
    chk("rd_ack_single", 0, 64'(obs_rd[0]), 64'd1);
    rd_req = 1'b0;
    step();
    chk("dvld_single", 0, 64'(obs_dvld[0]), 64'd1);
    chk("dout_single", 0, 64'(obs_dout[0]), 64'h1234);

    // Partial write.
    wr_req = 1'b1; wr_din = 16'hFF00; wr_bwe = 16'h00FF;
    step();
    wr_req = 1'b0; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    chk("dout_partial", 0, 64'(obs_dout[0]), 64'h1200);

    // Contention for 4 cycles.
    wr_req = 1'b1; rd_req = 1'b1; wr_add = 4'd7; rd_add = 4'd3; wr_din = 16'h0BEE; wr_bwe = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_wr", 0, 64'(obs_wr[0]), 64'(k % 2 == 0));
      chk("rr_rd", 0, 64'(obs_rd[0]), 64'(k % 2 == 1));
      chk("prio_wr", 1, 64'(obs_wr[1]), 64'd0);
      chk("prio_rd", 1, 64'(obs_rd[1]), 64'd1);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    step();

    // init_start alongside a read grant, then a restart mid-sweep at cnt 7.
    rd_req = 1'b1; rd_add = 4'd3; init_start = 1'b1;
    step();
    chk("rd_ack_with_init", 0, 64'(obs_rd[0]), 64'd1);
    rd_req = 1'b0; init_start = 1'b0;
    step();
    chk("dvld_after_init", 0, 64'(obs_dvld[0]), 64'd1);
    chk("dout_after_init", 0, 64'(obs_dout[0]), 64'h1200);
    chk("done_fell", 0, 64'(obs_done[0]), 64'd0);
    repeat (6) step();
    init_start = 1'b1;
    step();
    chk("restart_at7", 0, 64'(obs_add[0]), 64'd7);
    init_start = 1'b0;
    for (int k = 0; k < D; k++) begin
      step();
      chk("resweep_add", 0, 64'(obs_add[0]), 64'(k));
    end
    step();
    chk("done_resweep", 0, 64'(obs_done[0]), 64'd1);

    // Reset landing on the cycle a read's data would be valid.
    rd_req = 1'b1; rd_add = 4'd3;
    step();
    rd_req = 1'b0; rst_n = 1'b0;
    step();
    chk("dvld_dropped", 0, 64'(obs_dvld[0]), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_cs", 0, 64'(obs_cs[0]), 64'd1);
    chk("post_rst_add", 0, 64'(obs_add[0]), 64'd0);
    repeat (D) step();

    // Random traffic, occasional init_start and reset.
    for (int c = 0; c < 800; c++) begin
      wr_req = 1'($urandom_range(0, 1));
      rd_req = 1'($urandom_range(0, 1));
      wr_add = AW'($urandom_range(0, 3));
      rd_add = AW'($urandom_range(0, 3));
      wr_din = W'($urandom);
      wr_bwe = (c % 3 == 0) ? 16'hFFFF : W'($urandom);
      init_start = ($urandom_range(0, 99) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1; init_start = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nx_ram_1rw_ctl.md
Name: nx_ram_1rw_ctl

Overview:
- Controller that shares one single-port 1RW RAM (DEPTH x WIDTH, 1-cycle registered read, bit-enable write) between one write requester and one read requester.
- Owns the RAM's cs/we/add/din/bwe pins.
- Runs a hardware init sweep after reset or on request, writing INIT_VAL to every word.
- Sits between datapath clients and the RAM instance; the clients see a req/ack interface plus a read-data-valid strobe.

Parameters:
- WIDTH, 64, RAM word width in bits.
- DEPTH, 256, RAM depth in words; must be >= 2.
- INIT_VAL, 0, WIDTH-bit value written to every word during the init sweep.
- RD_PRIO, 0, contention policy: 0 = round-robin between read and write; 1 = read always wins.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- init_start  in  1  one-cycle pulse; (re)starts the init sweep.
- init_done  out  1  high when the sweep is complete and client traffic is allowed.
- wr_req  in  1  write request; held until wr_ack.
- wr_add  in  log2(DEPTH)  write address.
- wr_din  in  WIDTH  write data.
- wr_bwe  in  WIDTH  per-bit write enable.
- wr_ack  out  1  combinational; write is issued to the RAM this cycle.
- rd_req  in  1  read request; held until rd_ack.
- rd_add  in  log2(DEPTH)  read address.
- rd_ack  out  1  combinational; read is issued to the RAM this cycle.
- rd_dvld  out  1  registered; ram_dout is valid for the read acked in the previous cycle.
- rd_dout  out  WIDTH  pass-through of ram_dout.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_add  out  log2(DEPTH)  RAM address.
- ram_din  out  WIDTH  RAM write data.
- ram_bwe  out  WIDTH  RAM bit write enable.
- ram_dout  in  WIDTH  RAM read data; RAM registers it on the cycle after cs.

Behaviour:
- FSM states: INIT, IDLE.
- Reset state: INIT with init counter = 0.
  - Output values under reset: init_done=0, rd_dvld=0, rr pointer=write-first.
  - Combinational outputs under reset: wr_ack=0, rd_ack=0, ram_cs=0.
- INIT state:
  - Each cycle drives ram_cs=1, ram_we=1, ram_add=cnt, ram_din=INIT_VAL, ram_bwe=all ones.
  - cnt increments each cycle.
  - When cnt==DEPTH-1 the write issues and the next state is IDLE; init_done rises the following cycle.
  - The sweep takes exactly DEPTH cycles.
  - wr_ack and rd_ack are 0 throughout, and requests wait.
- init_start:
  - In any state, the next state is INIT with cnt=0 and init_done=0 the next cycle.
  - A mid-sweep init_start restarts the sweep from 0.
  - A grant made in the same cycle as init_start still completes.
- IDLE, single requester: grant it the same cycle.
  - Write: ram_cs=1, ram_we=1, and ram_add/din/bwe come from the wr_* inputs.
  - Read: ram_cs=1, ram_we=0, ram_add=rd_add, ram_bwe=0.
- IDLE, both requesting:
  - RD_PRIO=1: read wins.
  - RD_PRIO=0: round-robin. The pointer flips to favour the other side after each contended grant; uncontended grants do not move it.
- IDLE, no request: ram_cs=0.
- rd_dvld=1 exactly one cycle after rd_ack; rd_dout=ram_dout.
- Read-after-write ordering: a read acked the cycle after a write to the same address returns the new data, because the RAM updates on that clock edge. The controller adds no hazard logic.
- At most one RAM access per cycle. Maximum throughput is 1 access/cycle; a sustained dual stream under RR gives 50% each.
- Asynchronous reset mid-operation: all state clears immediately. An in-flight rd_dvld is dropped and the sweep restarts after reset release.
- ram_din and ram_add are don't-care when ram_cs=0; drive them to 0 for lint cleanliness.

Decomposition:
- Package nx_ram_1rw_ctl_pkg contains:
  - the state enum {INIT, IDLE};
  - grant encoding {GNT_NONE, GNT_WR, GNT_RD};
  - the localparam function for the address width.
- One natural sub-module: nx_rr_arb2, a 2-requester round-robin arbiter with a priority override input (used for RD_PRIO). It is reusable elsewhere.

Test Plan:
- Sweep and gate: release reset with DEPTH=16 and INIT_VAL=0xA5 -> ram_cs/ram_we high for 16 cycles on addresses 0..15; init_done=1 on cycle 17; backdoor read of every word = 0xA5. Hold rd_req high during the sweep -> rd_ack=0 until init_done.
- Single write then read: wr_req to addr 3, din 0x1234, bwe all ones -> wr_ack same cycle. rd_req addr 3 the next cycle -> rd_ack, then rd_dvld one cycle later with rd_dout=0x1234.
- Partial write: addr 3 holds 0x1234; write din=0xFF00, bwe=0x00FF -> readback 0x1200.
- Contention, RD_PRIO=0: wr_req and rd_req both high for 4 cycles -> grants alternate W,R,W,R starting with write after reset. With RD_PRIO=1 -> 4 read grants and no wr_ack.
- init_start mid-traffic: pulse init_start at sweep cnt=7 -> cnt returns to 0 and a full 16-cycle sweep follows. Pulse in IDLE alongside an rd_ack -> rd_dvld still asserts next cycle and init_done falls.
- Reset mid-read: assert rst_n=0 on the cycle after rd_ack -> rd_dvld=0 immediately; after release a new sweep starts at address 0.
